led_cycle_ctrl: RTL and testbench

Controller for the 16-channel LED PWM bank. It debounces the 5 board buttons into speed, pause, mode and direction commands, and runs a step timer. On each step, or on a mode change, it sequences a 16-entry duty-cycle frame into the PWM duty register bank over a valid/ready write port. It sits between the button inputs and the duty bank that feeds the per-LED PWM units.

---
 rtl/led_ctrl_pkg.sv | 46 ++++
 rtl/led_cycle_ctrl_if.sv | 12 +
 rtl/button_debounce.sv | 56 +++++
 rtl/led_cycle_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_led_cycle_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types, button indices and the duty-pattern generator for the LED cycle controller.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        COMET   = 2'd0,
        SINGLE  = 2'd1,
        BAR     = 2'd2,
        BREATHE = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    localparam int BTN_SLOWER = 0;
    localparam int BTN_FASTER = 1;
    localparam int BTN_PAUSE  = 2;
    localparam int BTN_MODE   = 3;
    localparam int BTN_REV    = 4;
    localparam int NUM_BTNS   = 5;
    localparam int NUM_LEDS   = 16;

    // Duty for LED a given the frame snapshot; the comet tail trails behind the head.
    function automatic logic [7:0] pattern_duty(mode_e m, logic [3:0] p, logic [3:0] a, logic rev);
        logic [3:0] d;
        logic [7:0] duty;
        d    = rev ? (a - p) : (p - a);
        duty = 8'd0;
        case (m)
            COMET: begin
                if (d < 4'd4) begin
                    duty = 8'hFF >> d;
                end else begin
                    duty = 8'd0;
                end
            end
            SINGLE:  duty = (a == p) ? 8'hFF : 8'h00;
            BAR:     duty = (a <= p) ? 8'hFF : 8'h00;
            BREATHE: duty = {p, p};
            default: duty = 8'd0;
        endcase
        return duty;
    endfunction

endpackage

// File: rtl/led_cycle_ctrl_if.sv
// Valid/ready write port from the controller into the PWM duty register bank.
interface led_cycle_ctrl_if #(
    parameter int DUTY_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [3:0]        wr_addr;
    logic [DUTY_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/button_debounce.sv
// One button: 2-FF synchronizer, stability counter and a single-cycle press pulse on debounced 0->1.
module button_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync1_q, sync2_q;
    logic             state_q, state_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchronizer, debounced state, stability counter and press pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any agreeing sample restarts the count, so only an unbroken run flips the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != state_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                state_d = ~state_q;
                cnt_d   = '0;
            end else begin
                state_d = state_q;
                cnt_d   = cnt_q + 1'b1;
            end
        end else begin
            state_d = state_q;
            cnt_d   = '0;
        end
        press_d = state_d & ~state_q;
    end

    assign press = press_q;

endmodule

// File: rtl/led_cycle_ctrl.sv
// LED cycle controller: button commands, step timer and the 16-entry duty frame writer.
module led_cycle_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int STEP_BASE    = 1000000,
    parameter int NUM_SPEEDS   = 5,
    parameter int DUTY_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_BTNS-1:0]     buttons,
    led_cycle_ctrl_if.master        wr,
    output logic                    busy,
    output logic [2:0]              speed_level,
    output logic [1:0]              mode,
    output logic                    paused,
    output logic                    dir,
    output logic [3:0]              pos
);
    localparam int         CNT_W     = $clog2(STEP_BASE * NUM_SPEEDS + 1);
    localparam logic [2:0] SPEED_MAX = 3'(NUM_SPEEDS - 1);
    localparam logic [3:0] LAST_ADDR = 4'(NUM_LEDS - 1);

    logic [NUM_BTNS-1:0] press_s;
    logic                tick_s, frame_req_s, load_s;
    logic [CNT_W-1:0]    period_m1_s;

    logic [2:0]        speed_q, speed_d;
    logic              paused_q, paused_d;
    mode_e             mode_q, mode_d;
    logic              dir_q, dir_d;
    logic [3:0]        pos_q, pos_d;
    logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;

    state_e            state_q, state_d;
    logic              pending_q, pending_d;
    logic [3:0]        addr_q, addr_d;
    logic [DUTY_W-1:0] data_q, data_d;
    mode_e             snap_mode_q, snap_mode_d;
    logic [3:0]        snap_pos_q, snap_pos_d;
    logic              snap_dir_q, snap_dir_d;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (buttons[i]),
            .press   (press_s[i])
        );
    end

    assign period_m1_s = CNT_W'(STEP_BASE * (NUM_SPEEDS - int'(speed_q)) - 1);

    // Control and timer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            speed_q    <= 3'd0;
            paused_q   <= 1'b0;
            mode_q     <= COMET;
            dir_q      <= 1'b0;
            pos_q      <= 4'd0;
            step_cnt_q <= '0;
        end else begin
            speed_q    <= speed_d;
            paused_q   <= paused_d;
            mode_q     <= mode_d;
            dir_q      <= dir_d;
            pos_q      <= pos_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // Step timer plus button commands; every command is applied independently in one cycle.
    always_comb begin
        speed_d    = speed_q;
        paused_d   = paused_q;
        mode_d     = mode_q;
        dir_d      = dir_q;
        pos_d      = pos_q;
        step_cnt_d = step_cnt_q;
        tick_s     = 1'b0;

        if (paused_q) begin
            step_cnt_d = step_cnt_q;
        end else if (step_cnt_q >= period_m1_s) begin
            step_cnt_d = '0;
            tick_s     = 1'b1;
        end else begin
            step_cnt_d = step_cnt_q + 1'b1;
        end

        // A real speed change restarts the period so the new rate takes effect cleanly.
        if (press_s[BTN_FASTER] && !press_s[BTN_SLOWER] && (speed_q != SPEED_MAX)) begin
            speed_d    = speed_q + 3'd1;
            step_cnt_d = '0;
        end else if (press_s[BTN_SLOWER] && !press_s[BTN_FASTER] && (speed_q != 3'd0)) begin
            speed_d    = speed_q - 3'd1;
            step_cnt_d = '0;
        end else begin
            speed_d = speed_q;
        end

        if (press_s[BTN_PAUSE]) begin
            paused_d = ~paused_q;
        end else begin
            paused_d = paused_q;
        end

        if (press_s[BTN_MODE]) begin
            mode_d = mode_e'(mode_q + 2'd1);
        end else begin
            mode_d = mode_q;
        end

        if (press_s[BTN_REV]) begin
            dir_d = ~dir_q;
        end else begin
            dir_d = dir_q;
        end

        if (tick_s) begin
            pos_d = dir_q ? (pos_q - 4'd1) : (pos_q + 4'd1);
        end else begin
            pos_d = pos_q;
        end

        frame_req_s = tick_s | press_s[BTN_MODE];
    end

    // Frame FSM state, write port and snapshot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= 1'b1;
            addr_q      <= 4'd0;
            data_q      <= '0;
            snap_mode_q <= COMET;
            snap_pos_q  <= 4'd0;
            snap_dir_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            snap_mode_q <= snap_mode_d;
            snap_pos_q  <= snap_pos_d;
            snap_dir_q  <= snap_dir_d;
        end
    end

    // Frame sequencing: snapshots take the post-update values so a triggering tick is shown.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        addr_d      = addr_q;
        snap_mode_d = snap_mode_q;
        snap_pos_d  = snap_pos_q;
        snap_dir_d  = snap_dir_q;
        load_s      = 1'b0;
        data_d      = '0;

        case (state_q)
            IDLE: begin
                if (frame_req_s || pending_q) begin
                    state_d = WRITE;
                    load_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (frame_req_s) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (wr.wr_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        if (frame_req_s || pending_q) begin
                            load_s = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        addr_d = addr_q + 4'd1;
                    end
                end else begin
                    addr_d = addr_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_s) begin
            addr_d      = 4'd0;
            pending_d   = 1'b0;
            snap_mode_d = mode_d;
            snap_pos_d  = pos_d;
            snap_dir_d  = dir_d;
        end else begin
            snap_mode_d = snap_mode_q;
        end

        if (state_d == WRITE) begin
            data_d = DUTY_W'(pattern_duty(snap_mode_d, snap_pos_d, addr_d, snap_dir_d));
        end else begin
            data_d = '0;
        end
    end

    assign wr.wr_valid  = (state_q == WRITE);
    assign wr.wr_addr   = addr_q;
    assign wr.wr_data   = data_q;
    assign busy         = (state_q == WRITE);
    assign speed_level  = speed_q;
    assign mode         = mode_q;
    assign paused       = paused_q;
    assign dir          = dir_q;
    assign pos          = pos_q;

endmodule

// File: tb/tb_led_cycle_ctrl.sv
// Directed bench for led_cycle_ctrl with short debounce and step periods.
module tb_led_cycle_ctrl;
    localparam int DEB = 4;
    localparam int SB  = 10;

    logic       clk, rst;
    logic [4:0] buttons;
    logic       busy, paused, dir;
    logic [2:0] speed_level;
    logic [1:0] mode;
    logic [3:0] pos;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0] cap_addr [0:31];
    logic [7:0] cap_data [0:31];
    int         cap_n, cap_gaps;

    led_cycle_ctrl_if #(.DUTY_W(8)) wr_if ();

    led_cycle_ctrl #(.DEBOUNCE_CYC(DEB), .STEP_BASE(SB), .NUM_SPEEDS(5), .DUTY_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .buttons     (buttons),
        .wr          (wr_if),
        .busy        (busy),
        .speed_level (speed_level),
        .mode        (mode),
        .paused      (paused),
        .dir         (dir),
        .pos         (pos)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] exp_duty(input int m, input int p, input int a, input bit rev);
        int d;
        logic [7:0] r;
        r = 8'd0;
        case (m)
            0: begin
                d = rev ? (a - p + 16) % 16 : (p - a + 16) % 16;
                case (d)
                    0: r = 8'd255;
                    1: r = 8'd127;
                    2: r = 8'd63;
                    3: r = 8'd31;
                    default: r = 8'd0;
                endcase
            end
            1: r = (a == p) ? 8'd255 : 8'd0;
            2: r = (a <= p) ? 8'd255 : 8'd0;
            default: r = 8'(p * 17);
        endcase
        return r;
    endfunction

    task automatic press(input int idx);
        buttons[idx] = 1'b1;
        repeat (DEB + 4) @(negedge clk);
        buttons[idx] = 1'b0;
        repeat (DEB + 4) @(negedge clk);
    endtask

    // Records handshakes (no checking) until target are seen or the budget runs out.
    task automatic capture(input int target);
        int g;
        g = 0;
        cap_n = 0;
        cap_gaps = 0;
        while (!wr_if.wr_valid && g < 60) begin
            @(negedge clk);
            g++;
        end
        wr_if.wr_ready = 1'b1;
        g = 0;
        while (cap_n < target && g < 200) begin
            if (wr_if.wr_valid) begin
                cap_addr[cap_n] = wr_if.wr_addr;
                cap_data[cap_n] = wr_if.wr_data;
                cap_n++;
            end else begin
                cap_gaps++;
            end
            @(negedge clk);
            g++;
        end
    endtask

    task automatic wait_pos_change(output int cycles);
        logic [3:0] p0;
        p0 = pos;
        cycles = 0;
        while (pos == p0 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        n_cmp++; if (wr_if.wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", wr_if.wr_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (speed_level !== 3'd0) begin n_fail++; $display("FAIL reset_speed: got %0d want 0", speed_level); end
        n_cmp++; if (mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d want 0", mode); end
        n_cmp++; if (paused !== 1'b0 || dir !== 1'b0) begin n_fail++; $display("FAIL reset_paused_dir: got %0b%0b want 00", paused, dir); end
        n_cmp++; if (pos !== 4'd0) begin n_fail++; $display("FAIL reset_pos: got %0d want 0", pos); end
        n_cmp++; if (wr_if.wr_addr !== 4'd0 || wr_if.wr_data !== 8'd0) begin n_fail++; $display("FAIL reset_bus: got addr %0d data %0d want 0 0", wr_if.wr_addr, wr_if.wr_data); end
    endtask

    task automatic test_first_frame();
        logic [7:0] e;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (wr_if.wr_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %0b want 1", wr_if.wr_valid); end
        capture(16);
        n_cmp++; if (cap_n !== 16 || cap_gaps !== 0) begin n_fail++; $display("FAIL first_count: got %0d writes %0d gaps want 16 0", cap_n, cap_gaps); end
        for (int i = 0; i < cap_n; i++) begin
            e = (i == 0) ? 8'd255 : (i == 13) ? 8'd31 : (i == 14) ? 8'd63 : (i == 15) ? 8'd127 : 8'd0;
            n_cmp++; if (cap_addr[i] !== 4'(i) || cap_data[i] !== e) begin n_fail++; $display("FAIL first_entry %0d: got addr %0d data %0d want %0d %0d", i, cap_addr[i], cap_data[i], i, e); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL first_busy_end: got %0b want 0", busy); end
    endtask

    task automatic test_stall();
        int g, n;
        bit stalled;
        logic [7:0] held;
        g = 0;
        while (!wr_if.wr_valid && g < 120) begin @(negedge clk); g++; end
        n = 0;
        stalled = 1'b0;
        g = 0;
        while (n < 16 && g < 100) begin
            if (wr_if.wr_valid) begin
                if (wr_if.wr_addr == 4'd7 && !stalled) begin
                    stalled = 1'b1;
                    wr_if.wr_ready = 1'b0;
                    held = wr_if.wr_data;
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clk);
                        n_cmp++; if (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== 4'd7 || wr_if.wr_data !== held) begin
                            n_fail++; $display("FAIL stall_hold %0d: got v%0b a%0d d%0d want v1 a7 d%0d", k, wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data, held);
                        end
                    end
                    wr_if.wr_ready = 1'b1;
                end
                n_cmp++; if (wr_if.wr_addr !== 4'(n) || wr_if.wr_data !== exp_duty(0, 1, n, 1'b0)) begin
                    n_fail++; $display("FAIL stall_entry %0d: got addr %0d data %0d want %0d %0d", n, wr_if.wr_addr, wr_if.wr_data, n, exp_duty(0, 1, n, 1'b0));
                end
                n++;
            end
            @(negedge clk);
            g++;
        end
        n_cmp++; if (n !== 16 || !stalled || busy !== 1'b0) begin n_fail++; $display("FAIL stall_frame: got %0d handshakes stalled %0b busy %0b want 16 1 0", n, stalled, busy); end
    endtask

    task automatic test_speed();
        int c;
        wait_pos_change(c);
        wait_pos_change(c);
        n_cmp++; if (c !== 50) begin n_fail++; $display("FAIL speed0_period: got %0d want 50", c); end
        for (int i = 0; i < 6; i++) begin
            press(1);
            n_cmp++; if (speed_level !== 3'((i + 1 > 4) ? 4 : i + 1)) begin n_fail++; $display("FAIL faster_%0d: got %0d want %0d", i, speed_level, (i + 1 > 4) ? 4 : i + 1); end
        end
        wait_pos_change(c);
        wait_pos_change(c);
        n_cmp++; if (c !== 10) begin n_fail++; $display("FAIL speed4_period: got %0d want 10", c); end
    endtask

    task automatic test_pause();
        logic [3:0] p0;
        int c;
        press(2);
        n_cmp++; if (paused !== 1'b1) begin n_fail++; $display("FAIL pause_on: got %0b want 1", paused); end
        p0 = pos;
        repeat (200) @(negedge clk);
        n_cmp++; if (pos !== p0) begin n_fail++; $display("FAIL pause_frozen: got %0d want %0d", pos, p0); end
        press(2);
        n_cmp++; if (paused !== 1'b0) begin n_fail++; $display("FAIL pause_off: got %0b want 0", paused); end
        wait_pos_change(c);
        n_cmp++; if (c >= 20) begin n_fail++; $display("FAIL pause_resume: got %0d cycles want below 20", c); end
    endtask

    task automatic test_reverse_mode();
        logic [3:0] prev;
        int c, g;
        for (int i = 0; i < 5; i++) press(0);
        n_cmp++; if (speed_level !== 3'd0) begin n_fail++; $display("FAIL slower_sat: got %0d want 0", speed_level); end
        prev = pos;
        g = 0;
        while (g < 1000) begin
            @(negedge clk);
            g++;
            if (pos == 4'd0 && prev == 4'd15) break;
            prev = pos;
        end
        press(2);
        n_cmp++; if (paused !== 1'b1 || pos !== 4'd0) begin n_fail++; $display("FAIL rev_setup: got paused %0b pos %0d want 1 0", paused, pos); end
        press(4);
        n_cmp++; if (dir !== 1'b1) begin n_fail++; $display("FAIL rev_dir: got %0b want 1", dir); end
        press(2);
        wait_pos_change(c);
        n_cmp++; if (pos !== 4'd15) begin n_fail++; $display("FAIL rev_wrap: got %0d want 15", pos); end
        press(2);
        n_cmp++; if (paused !== 1'b1 || pos !== 4'd15) begin n_fail++; $display("FAIL rev_hold: got paused %0b pos %0d want 1 15", paused, pos); end
        repeat (4) @(negedge clk);
        for (int m = 1; m <= 2; m++) begin
            wr_if.wr_ready = 1'b0;
            press(3);
            n_cmp++; if (mode !== 2'(m)) begin n_fail++; $display("FAIL mode_step: got %0d want %0d", mode, m); end
            capture(16);
            n_cmp++; if (cap_n !== 16 || busy !== 1'b0) begin n_fail++; $display("FAIL mode_frame_len: got %0d busy %0b want 16 0", cap_n, busy); end
            for (int i = 0; i < cap_n; i++) begin
                n_cmp++; if (cap_addr[i] !== 4'(i) || cap_data[i] !== exp_duty(m, 15, i, 1'b1)) begin
                    n_fail++; $display("FAIL mode%0d_entry %0d: got addr %0d data %0d want %0d %0d", m, i, cap_addr[i], cap_data[i], i, exp_duty(m, 15, i, 1'b1));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        logic [3:0] ea;
        logic [7:0] ed;
        buttons[1] = 1'b1;
        repeat (3) @(negedge clk);
        buttons[1] = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (speed_level !== 3'd0) begin n_fail++; $display("FAIL glitch_speed: got %0d want 0", speed_level); end
        wr_if.wr_ready = 1'b0;
        press(3);
        n_cmp++; if (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== 4'd0 || mode !== 2'd3) begin n_fail++; $display("FAIL b2b_start: got v%0b a%0d m%0d want v1 a0 m3", wr_if.wr_valid, wr_if.wr_addr, mode); end
        press(3);
        press(2);
        wait_pos_change(c);
        n_cmp++; if (pos !== 4'd14) begin n_fail++; $display("FAIL b2b_tick: got %0d want 14", pos); end
        press(2);
        capture(32);
        n_cmp++; if (cap_n !== 32 || cap_gaps !== 0) begin n_fail++; $display("FAIL b2b_count: got %0d writes %0d gaps want 32 0", cap_n, cap_gaps); end
        for (int i = 0; i < cap_n; i++) begin
            ea = 4'(i % 16);
            ed = (i < 16) ? exp_duty(3, 15, i, 1'b1) : exp_duty(0, 14, i - 16, 1'b1);
            n_cmp++; if (cap_addr[i] !== ea || cap_data[i] !== ed) begin n_fail++; $display("FAIL b2b_entry %0d: got addr %0d data %0d want %0d %0d", i, cap_addr[i], cap_data[i], ea, ed); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got %0b want 0", busy); end
        repeat (5) @(negedge clk);
        n_cmp++; if (wr_if.wr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_third: got %0b want 0", wr_if.wr_valid); end
    endtask

    task automatic test_reset_abort();
        wr_if.wr_ready = 1'b0;
        press(3);
        n_cmp++; if (wr_if.wr_valid !== 1'b1) begin n_fail++; $display("FAIL abort_setup: got %0b want 1", wr_if.wr_valid); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (wr_if.wr_valid !== 1'b0 || busy !== 1'b0 || mode !== 2'd0 || dir !== 1'b0 || paused !== 1'b0) begin
            n_fail++; $display("FAIL abort_reset: got v%0b b%0b m%0d d%0b p%0b want all 0", wr_if.wr_valid, busy, mode, dir, paused);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== 4'd0 || wr_if.wr_data !== 8'd255) begin
            n_fail++; $display("FAIL abort_restart: got v%0b a%0d d%0d want v1 a0 d255", wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data);
        end
    endtask

    initial begin
        rst = 1'b1;
        buttons = 5'd0;
        wr_if.wr_ready = 1'b1;
        test_reset();
        test_first_frame();
        test_stall();
        test_speed();
        test_pause();
        test_reverse_mode();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
